// File: rtl/wave_gen_pkg.sv
// rtl/wave_gen_pkg.sv - shared modes, default widths and config record for wave_gen_param (WAVE_GEN_OFFSET_EN adds offset)
package wave_gen_pkg;

    localparam int DW_DEF = 8;
    localparam int PW_DEF = 8;
    // Config record fields are sized for the widest supported DW/PW (<= 16).
    localparam int CFG_W  = 16;

    typedef enum logic [1:0] {
        MODE_SQUARE = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_OFF    = 2'd3
    } wave_mode_e;

    typedef struct packed {
        wave_mode_e       mode;
        logic [CFG_W-1:0] period;
        logic [CFG_W-1:0] duty;
        logic [CFG_W-1:0] amp;
`ifdef WAVE_GEN_OFFSET_EN
        logic [CFG_W-1:0] offset;
`endif
    } wave_cfg_t;

    function automatic wave_cfg_t cfg_reset();
        wave_cfg_t c;
        c.mode   = MODE_OFF;
        c.period = '0;
        c.duty   = '0;
        c.amp    = '0;
`ifdef WAVE_GEN_OFFSET_EN
        c.offset = '0;
`endif
        return c;
    endfunction

endpackage

// File: rtl/wave_gen_cfg_shadow.sv
// rtl/wave_gen_cfg_shadow.sv - double-buffered config: shadow, active, pending flag and boundary apply
module wave_gen_cfg_shadow
    import wave_gen_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      en,
    input  logic      cfg_load,
    input  wave_cfg_t cfg_in,
    input  logic      cycle_last,
    output wave_cfg_t active,
    output logic      apply
);
    wave_cfg_t shadow;
    logic      pending;

    // A strobe landing on the boundary edge itself is applied straight from the inputs.
    assign apply = en && (pending || cfg_load) && (cycle_last || active.mode == MODE_OFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= cfg_reset();
            active  <= cfg_reset();
            pending <= 1'b0;
        end else begin
            if (cfg_load) begin
                shadow <= cfg_in;
            end
            if (apply) begin
                active  <= cfg_load ? cfg_in : shadow;
                pending <= 1'b0;
            end else if (cfg_load) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/wave_gen_param.sv
// rtl/wave_gen_param.sv - square/sawtooth/triangle generator, one sample per enabled clock
// WAVE_GEN_OFFSET_EN adds a saturating output offset captured with the config.
module wave_gen_param
    import wave_gen_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int PW = PW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          cfg_load,
    input  logic [1:0]    mode,
    input  logic [PW-1:0] period,
    input  logic [PW-1:0] duty,
    input  logic [DW-1:0] amp,
`ifdef WAVE_GEN_OFFSET_EN
    input  logic [DW-1:0] offset,
`endif
    output logic [DW-1:0] wave,
    output logic          wave_vld,
    output logic          cycle_done
);
    localparam int PHW = (DW > PW) ? DW : PW;

    wave_cfg_t      cfg_in;
    wave_cfg_t      active;
    logic           apply;
    logic           last;
    logic           dir;
    logic           dir_next;
    logic [PHW-1:0] phase;
    logic [PHW-1:0] ph_next;
    logic [DW-1:0]  shape;
    logic [DW-1:0]  sample;
    logic [DW-1:0]  a_amp;
    logic [PW-1:0]  a_period;
    logic [PW-1:0]  a_duty;
    logic [PW-1:0]  per_eff;
    logic           unused_cfg_bits;

    always_comb begin
        cfg_in        = cfg_reset();
        cfg_in.mode   = wave_mode_e'(mode);
        cfg_in.period = CFG_W'(period);
        cfg_in.duty   = CFG_W'(duty);
        cfg_in.amp    = CFG_W'(amp);
`ifdef WAVE_GEN_OFFSET_EN
        cfg_in.offset = CFG_W'(offset);
`endif
    end

    wave_gen_cfg_shadow u_cfg (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_load   (cfg_load),
        .cfg_in     (cfg_in),
        .cycle_last (last),
        .active     (active),
        .apply      (apply)
    );

    assign a_period = PW'(active.period);
    assign a_duty   = PW'(active.duty);
    assign a_amp    = DW'(active.amp);
    assign per_eff  = (a_period == '0) ? PW'(1) : a_period;
    assign unused_cfg_bits = ^{active.period >> PW, active.duty >> PW, active.amp >> DW};

    // Square uses phase as a sample index; saw/triangle use it as the current level.
    always_comb begin
        last     = 1'b0;
        shape    = '0;
        ph_next  = phase;
        dir_next = dir;
        case (active.mode)
            MODE_SQUARE: begin
                shape   = (phase < PHW'(a_duty)) ? a_amp : '0;
                last    = (phase >= PHW'(per_eff - PW'(1)));
                ph_next = last ? '0 : phase + PHW'(1);
            end
            MODE_SAW: begin
                shape   = DW'(phase);
                last    = (DW'(phase) >= a_amp);
                ph_next = last ? '0 : phase + PHW'(1);
            end
            MODE_TRI: begin
                shape = DW'(phase);
                if (a_amp == '0) begin
                    last    = 1'b1;
                    ph_next = '0;
                end else if (!dir) begin
                    if (DW'(phase) >= a_amp) begin
                        if (a_amp == DW'(1)) begin
                            last    = 1'b1;
                            ph_next = '0;
                        end else begin
                            dir_next = 1'b1;
                            ph_next  = PHW'(a_amp - DW'(1));
                        end
                    end else begin
                        ph_next = phase + PHW'(1);
                    end
                end else if (phase <= PHW'(1)) begin
                    last     = 1'b1;
                    ph_next  = '0;
                    dir_next = 1'b0;
                end else begin
                    ph_next = phase - PHW'(1);
                end
            end
            default: begin
                last = 1'b0;
            end
        endcase
    end

`ifdef WAVE_GEN_OFFSET_EN
    logic [DW:0] sum;
    logic        unused_off_bits;
    assign sum             = {1'b0, shape} + {1'b0, DW'(active.offset)};
    assign sample          = sum[DW] ? '1 : sum[DW-1:0];
    assign unused_off_bits = ^(active.offset >> DW);
`else
    assign sample = shape;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= '0;
            dir        <= 1'b0;
            wave       <= '0;
            wave_vld   <= 1'b0;
            cycle_done <= 1'b0;
        end else if (en) begin
            wave       <= (active.mode == MODE_OFF) ? '0 : sample;
            wave_vld   <= (active.mode != MODE_OFF);
            cycle_done <= last;
            if (apply) begin
                phase <= '0;
                dir   <= 1'b0;
            end else begin
                phase <= ph_next;
                dir   <= dir_next;
            end
        end else begin
            wave_vld   <= 1'b0;
            cycle_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wave_gen_param.sv
// tb/tb_wave_gen_param.sv - self-checking bench for wave_gen_param (WAVE_GEN_OFFSET_EN adds offset cases)
module tb_wave_gen_param;
    localparam int DW   = 8;
    localparam int PW   = 8;
    localparam int MAXV = (1 << DW) - 1;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          en       = 1'b0;
    logic          cfg_load = 1'b0;
    logic [1:0]    mode     = 2'd0;
    logic [PW-1:0] period   = '0;
    logic [PW-1:0] duty     = '0;
    logic [DW-1:0] amp      = '0;
    logic [DW-1:0] offset   = '0;
    logic [DW-1:0] wave;
    logic          wave_vld;
    logic          cycle_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wave_gen_param #(.DW(DW), .PW(PW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_load   (cfg_load),
        .mode       (mode),
        .period     (period),
        .duty       (duty),
        .amp        (amp),
`ifdef WAVE_GEN_OFFSET_EN
        .offset     (offset),
`endif
        .wave       (wave),
        .wave_vld   (wave_vld),
        .cycle_done (cycle_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one full waveform cycle listed as a sample queue, indexed per enabled clock.
    int q[$];
    int idx;
    int a_mode, a_per, a_duty, a_amp, a_off;
    int s_mode, s_per, s_duty, s_amp, s_off;
    bit pend;
    int e_wave;
    bit e_vld, e_cd;
    int m_v;
    bit m_bnd;

    function automatic void build();
        int p;
        q.delete();
        if (a_mode == 0) begin
            p = (a_per == 0) ? 1 : a_per;
            for (int i = 0; i < p; i++) q.push_back((i < a_duty) ? a_amp : 0);
        end else if (a_mode == 1) begin
            for (int i = 0; i <= a_amp; i++) q.push_back(i);
        end else if (a_mode == 2 && a_amp > 0) begin
            for (int i = 0; i <= a_amp; i++) q.push_back(i);
            for (int i = a_amp - 1; i >= 1; i--) q.push_back(i);
        end else begin
            q.push_back(0);
        end
    endfunction

    function automatic void capture_shadow();
        s_mode = int'(mode);
        s_per  = int'(period);
        s_duty = int'(duty);
        s_amp  = int'(amp);
`ifdef WAVE_GEN_OFFSET_EN
        s_off  = int'(offset);
`else
        s_off  = 0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_mode = 3; a_per = 0; a_duty = 0; a_amp = 0; a_off = 0;
            s_mode = 3; s_per = 0; s_duty = 0; s_amp = 0; s_off = 0;
            pend = 0; idx = 0; build();
            e_wave = 0; e_vld = 0; e_cd = 0;
        end else if (en) begin
            if (a_mode == 3) begin
                e_wave = 0; e_vld = 0; e_cd = 0; m_bnd = 1;
            end else begin
                m_v = q[idx] + a_off;
                if (m_v > MAXV) m_v = MAXV;
                e_wave = m_v;
                e_vld  = 1;
                e_cd   = (idx == q.size() - 1);
                m_bnd  = e_cd;
                idx    = (idx + 1) % q.size();
            end
            if (m_bnd && (pend || cfg_load)) begin
                if (cfg_load) capture_shadow();
                a_mode = s_mode; a_per = s_per; a_duty = s_duty; a_amp = s_amp; a_off = s_off;
                pend = 0; idx = 0; build();
            end else if (cfg_load) begin
                capture_shadow();
                pend = 1;
            end
        end else begin
            e_vld = 0; e_cd = 0;
            if (cfg_load) begin
                capture_shadow();
                pend = 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_wave", 32'(wave), 32'(e_wave));
        chk("model_vld", 32'(wave_vld), 32'(e_vld));
        chk("model_cd", 32'(cycle_done), 32'(e_cd));
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic load(input int m, input int p, input int d, input int a, input int o);
        mode     = 2'(m);
        period   = PW'(p);
        duty     = PW'(d);
        amp      = DW'(a);
        offset   = DW'(o);
        cfg_load = 1'b1;
        cyc();
        cfg_load = 1'b0;
    endtask

    task automatic expect_seq(input string name, input int vals[$], input int cds[$], input int vld);
        for (int i = 0; i < vals.size(); i++) begin
            cyc();
            chk({name, "_wave"}, 32'(wave), 32'(vals[i]));
            chk({name, "_cd"}, 32'(cycle_done), 32'(cds[i]));
            chk({name, "_vld"}, 32'(wave_vld), 32'(vld));
        end
    endtask

    initial begin
        cyc();
        cyc();
        chk("rst_wave", 32'(wave), 32'd0);
        chk("rst_vld", 32'(wave_vld), 32'd0);
        chk("rst_cd", 32'(cycle_done), 32'd0);
        rst_n = 1'b1;
        en    = 1'b1;

        load(0, 4, 1, 200, 0);
        expect_seq("sq_p4d1", '{200, 0, 0, 0, 200, 0, 0, 0}, '{0, 0, 0, 1, 0, 0, 0, 1}, 1);

        load(2, 0, 0, 3, 0);
        expect_seq("tri_a3", '{0, 0, 0, 0, 1, 2, 3, 2, 1, 0, 1}, '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0}, 1);

        load(1, 0, 0, 5, 0);
        expect_seq("to_saw", '{3, 2, 1, 0, 1}, '{0, 0, 1, 0, 0}, 1);
        load(2, 0, 0, 2, 0);
        expect_seq("saw_to_tri", '{3, 4, 5, 0, 1, 2, 1, 0}, '{0, 0, 1, 0, 0, 0, 1, 0}, 1);

        load(1, 0, 0, 7, 0);
        load(1, 0, 0, 9, 0);
        expect_seq("latest_wins", '{1, 0, 1, 2}, '{1, 0, 0, 0}, 1);
        en = 1'b0;
        expect_seq("freeze", '{2, 2, 2}, '{0, 0, 0}, 0);
        en = 1'b1;
        expect_seq("resume", '{3, 4, 5, 6, 7, 8, 9, 0}, '{0, 0, 0, 0, 0, 0, 1, 0}, 1);

        load(0, 0, 0, 50, 0);
        expect_seq("sq_p0", '{2, 3, 4, 5, 6, 7, 8, 9, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1}, 1);
        load(0, 4, 10, 77, 0);
        expect_seq("sq_full", '{77, 77, 77, 77, 77}, '{0, 0, 0, 1, 0}, 1);
        load(1, 0, 0, 0, 0);
        expect_seq("saw_a0", '{77, 77, 0, 0}, '{0, 1, 1, 1}, 1);
        load(3, 0, 0, 0, 0);
        expect_seq("off", '{0, 0}, '{0, 0}, 0);

`ifdef WAVE_GEN_OFFSET_EN
        load(1, 0, 0, 10, 250);
        expect_seq("offset_sat", '{250, 251, 252, 253, 254, 255, 255, 255, 255, 255, 255},
                   '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1}, 1);
`endif

        load(1, 0, 0, 5, 0);
        cyc();
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_wave", 32'(wave), 32'd0);
        chk("midrst_vld", 32'(wave_vld), 32'd0);
        chk("midrst_cd", 32'(cycle_done), 32'd0);
        cyc();
        rst_n = 1'b1;
        expect_seq("post_rst_off", '{0, 0, 0}, '{0, 0, 0}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wave_gen_param.md
Name: wave_gen_param

Overview:
Parametrised multi-mode waveform generator: square with programmable period and duty, sawtooth, and triangle with programmable amplitude.
- Configuration is double-buffered; new settings take effect only at a waveform-cycle boundary, so output shapes are never torn.
- Feeds DAC/test-pattern paths; one sample per enabled clock.

Parameters:
DW, 8, output sample width; amplitude range 0..2^DW-1
PW, 8, square period/duty counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
en  in  1  advance enable; low freezes all state
cfg_load  in  1  single-cycle strobe: capture mode/period/duty/amp into shadow
mode  in  2  0 square, 1 sawtooth, 2 triangle, 3 off
period  in  PW  square period in samples; 0 treated as 1
duty  in  PW  square high samples per period
amp  in  DW  peak value for all modes
wave  out  DW  registered sample
wave_vld  out  1  registered; 1 when wave carries a live sample
cycle_done  out  1  registered; high on the last sample of each waveform cycle

Behaviour:
- Reset: wave=0, wave_vld=0, cycle_done=0.
- Reset state: active mode=3 (off), active period/duty/amp=0, phase=0, pending=0, triangle direction=up.
- Reset mid-operation aborts immediately; no partial state survives.
- All outputs registered. One sample per clk with en=1.
- en=0: wave, phase, direction and outputs hold; wave_vld=0; cycle_done=0. cfg_load is still captured.
- cfg_load sets shadow registers and pending=1.
  - A second cfg_load while pending overwrites the shadow; latest wins.
- Apply: at an edge with en=1 and pending=1, when the sample being produced is the last of its cycle (the edge that also drives cycle_done=1), or active mode is 3:
  - active <= shadow, pending <= 0.
  - Phase and direction reset, so the next sample is sample 0 of the new configuration.
  - If cfg_load coincides with an apply edge, its input values are applied directly (bypass) and pending ends 0.
- Square: phase counts 0..P-1 (P=max(period,1)) and wraps.
  - wave = amp when phase<duty, else 0.
  - duty=0 gives a constant 0; duty>=P gives a constant amp.
  - cycle_done on phase=P-1.
- Sawtooth: wave 0,1,...,amp, then wraps to 0. Period amp+1. cycle_done on sample amp.
- Triangle: 0,1,...,amp,amp-1,...,1, then repeats from 0. Period 2*amp. cycle_done on sample 1 of the descent.
- amp=0 in sawtooth/triangle: constant 0, cycle_done every sample.
- Mode 3: wave=0, wave_vld=0, cycle_done=0. Pending config applies on the next en=1 edge.
- Latency: sample n of a cycle appears on wave on the clk edge following the edge that advanced phase to n; first sample after apply is sample 0.
- Arithmetic: unsigned DW bits throughout; never wraps beyond amp.

Optional Feature:
WAVE_GEN_OFFSET_EN
- Defined:
  - Adds input port offset (in, DW) captured with cfg_load into shadow/active.
  - wave = min(shape + offset, 2^DW-1), saturating; mode 3 still outputs 0.
- Undefined: no offset port, and wave is the raw shape.

Decomposition:
- wave_gen_pkg:
  - mode encodings MODE_SQUARE=0, MODE_SAW=1, MODE_TRI=2, MODE_OFF=3.
  - default DW/PW constants.
  - config struct typedef (mode, period, duty, amp[, offset]).
- Sub-module wave_gen_cfg_shadow:
  - holds shadow and active registers, pending flag, bypass/apply logic.
  - Top-level keeps phase/direction and sample generation.

Test Plan:
- Reset then cfg_load mode=0, period=4, duty=1, amp=200, en=1 -> wave 200,0,0,0 repeating; cycle_done on each 4th sample; wave_vld=1.
- Mode 2, amp=3 -> wave 0,1,2,3,2,1,0,1...; cycle_done on the sample 1 that follows 2.
- Running sawtooth amp=5; cfg_load mode=2 amp=2 at sample 2 -> saw completes 3,4,5, then triangle starts 0,1,2,1.
- Two cfg_loads mid-cycle (amp=7 then amp=9) -> only amp=9 applied at boundary; en held low 3 cycles mid-cycle -> wave frozen, wave_vld=0, sequence resumes unchanged.
- Square period=0 duty=0 -> constant 0, cycle_done every sample; duty=10 period=4 -> constant amp; saw amp=0 -> constant 0.
- With WAVE_GEN_OFFSET_EN, DW=8, sawtooth amp=10 offset=250 -> 250..255 then saturates at 255; assert rst_n low mid-cycle -> all outputs 0 next sample, mode off.
